// File: rtl/piped_decoded_mux.sv
// piped_decoded_mux: one-hot-select mux behind a 2-entry skid buffer with select-error tracking.
// Define PIPED_DECODED_MUX_ERR_CNT_EN to build the saturating error counter; otherwise err_count is 0.
module piped_decoded_mux #(
  parameter int VALUE_WIDTH   = 32,
  parameter int MUX_WIDTH     = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [MUX_WIDTH*VALUE_WIDTH-1:0] in_data,
  input  logic [MUX_WIDTH-1:0]             in_sel,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [VALUE_WIDTH-1:0]           out_data,
  output logic [$clog2(MUX_WIDTH)-1:0]     out_idx,
  output logic                             out_sel_err,
  output logic                             err_sticky,
  output logic [ERR_CNT_WIDTH-1:0]         err_count,
  input  logic                             err_clr
);
  localparam int IDX_W = $clog2(MUX_WIDTH);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t                 r_state;
  logic                   r_in_ready, r_out_valid, r_out_err, r_skid_err, r_sticky;
  logic [VALUE_WIDTH-1:0] r_out_data, r_skid_data, w_mux;
  logic [IDX_W-1:0]       r_out_idx, r_skid_idx, w_idx;
  logic                   w_err, w_acc, w_del, w_acc_err;
  // Descending scan so the lowest set select bit wins the index.
  always_comb begin
    w_mux = '0;
    w_idx = '0;
    for (int i = MUX_WIDTH - 1; i >= 0; i--)
      if (in_sel[i]) begin
        w_mux = w_mux | in_data[i*VALUE_WIDTH +: VALUE_WIDTH];
        w_idx = IDX_W'(i);
      end
  end
  assign w_err     = $countones(in_sel) != 1;
  assign w_acc     = in_valid & r_in_ready;
  assign w_del     = r_out_valid & out_ready;
  assign w_acc_err = w_acc & w_err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_err   <= 1'b0;
      r_skid_data <= '0;
      r_skid_idx  <= '0;
      r_skid_err  <= 1'b0;
      r_sticky    <= 1'b0;
    end else begin
      r_sticky <= err_clr ? w_acc_err : r_sticky | w_acc_err;
      case (r_state)
        EMPTY:
          if (w_acc) begin
            {r_out_data, r_out_idx, r_out_err} <= {w_mux, w_idx, w_err};
            r_out_valid <= 1'b1;
            r_state     <= ONE;
          end
        ONE:
          if (w_acc && !w_del) begin
            {r_skid_data, r_skid_idx, r_skid_err} <= {w_mux, w_idx, w_err};
            r_in_ready <= 1'b0;
            r_state    <= FULL;
          end else if (w_acc) begin
            {r_out_data, r_out_idx, r_out_err} <= {w_mux, w_idx, w_err};
          end else if (w_del) begin
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end
        FULL:
          if (w_del) begin
            {r_out_data, r_out_idx, r_out_err} <= {r_skid_data, r_skid_idx, r_skid_err};
            r_in_ready <= 1'b1;
            r_state    <= ONE;
          end
        default: r_state <= EMPTY;
      endcase
    end
  end
`ifdef PIPED_DECODED_MUX_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] r_err_count;
  always_ff @(posedge clk) begin
    if (!rst_n) r_err_count <= '0;
    else if (err_clr) r_err_count <= w_acc_err ? ERR_CNT_WIDTH'(1) : '0;
    else if (w_acc_err && r_err_count != '1) r_err_count <= r_err_count + 1'b1;
  end
  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_idx     = r_out_idx;
  assign out_sel_err = r_out_err;
  assign err_sticky  = r_sticky;
endmodule

// File: tb/tb_piped_decoded_mux.sv
// tb_piped_decoded_mux: randomized and directed stimulus against a queue-based reference of the skid-buffered mux.
module tb_piped_decoded_mux;
  localparam int VW = 32, MW = 4, EW = 2;
  logic           clk = 1'b0, rst_n = 1'b0;
  logic           in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [MW*VW-1:0] in_data = '0;
  logic [MW-1:0]  in_sel = '0;
  logic [VW-1:0]  out_data;
  logic [1:0]     out_idx;
  logic           out_sel_err, err_sticky, err_clr = 1'b0;
  logic [EW-1:0]  err_count;
  typedef struct {logic [VW-1:0] data; int idx; logic err;} beat_t;
  beat_t q[$];
  logic  m_sticky;
  int    m_cnt, n_chk, n_pass;
  piped_decoded_mux #(.VALUE_WIDTH(VW), .MUX_WIDTH(MW), .ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_sel_err(out_sel_err), .err_sticky(err_sticky),
    .err_count(err_count), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic check_outputs();
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_data", out_data, q[0].data);
      check("out_idx", 32'(out_idx), 32'(q[0].idx));
      check("out_sel_err", 32'(out_sel_err), 32'(q[0].err));
    end
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    check("err_count", 32'(err_count), 32'(m_cnt));
  endtask
  function automatic beat_t ref_beat(input logic [MW-1:0] sel, input logic [MW*VW-1:0] d);
    beat_t b;
    int ones;
    b.data = '0;
    b.idx = 0;
    ones = 0;
    for (int i = 0; i < MW; i++)
      if (sel[i]) begin
        b.data |= d[i*VW +: VW];
        if (ones == 0) b.idx = i;
        ones++;
      end
    b.err = ones != 1;
    return b;
  endfunction
  task automatic step(input logic v, input logic [MW-1:0] sel, input logic [MW*VW-1:0] d,
                      input logic ordy, input logic clr);
    logic acc, del;
    beat_t b;
    check_outputs();
    in_valid = v; in_sel = sel; in_data = d; out_ready = ordy; err_clr = clr;
    acc = v && q.size() < 2;
    del = q.size() > 0 && ordy;
    b = ref_beat(sel, d);
    if (del) void'(q.pop_front());
    if (acc) q.push_back(b);
    if (clr) m_sticky = acc && b.err;
    else m_sticky = m_sticky | (acc && b.err);
`ifdef PIPED_DECODED_MUX_ERR_CNT_EN
    if (clr) m_cnt = (acc && b.err) ? 1 : 0;
    else if (acc && b.err && m_cnt < (1 << EW) - 1) m_cnt++;
`endif
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    m_sticky = 1'b0;
    m_cnt = 0;
    check_outputs();
    rst_n = 1'b1;
  endtask
  function automatic logic [MW*VW-1:0] pack(input logic [VW-1:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction
  function automatic logic [MW*VW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [MW-1:0] rnd_sel();
    return ($urandom_range(0, 3) == 0) ? MW'($urandom) : MW'(1 << $urandom_range(0, MW - 1));
  endfunction
  initial begin
    n_chk = 0; n_pass = 0; m_sticky = 1'b0; m_cnt = 0;
    @(negedge clk);
    do_reset();
    // streaming one-hot beats with downstream always ready
    step(1'b1, 4'b0100, pack(32'h1, 32'h2, 32'hA5A5A5A5, 32'h3), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0100, pack(0, 0, 32'(i * 17 + 5), 0), 1'b1, 1'b0);
    step(1'b0, 4'b0, '0, 1'b1, 1'b0);
    // backpressure: fill, hold a third beat off, then drain
    step(1'b1, 4'b0001, pack(32'h11, 0, 0, 0), 1'b0, 1'b0);
    step(1'b1, 4'b0010, pack(0, 32'h22, 0, 0), 1'b0, 1'b0);
    step(1'b1, 4'b1000, pack(0, 0, 0, 32'h33), 1'b0, 1'b0);
    step(1'b1, 4'b1000, pack(0, 0, 0, 32'h33), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0, '0, 1'b1, 1'b0);
    // select errors: all-zero then multi-hot
    step(1'b1, 4'b0000, rnd_data(), 1'b1, 1'b0);
    step(1'b1, 4'b0110, pack(32'h5, 32'h0F, 32'hF0, 32'h9), 1'b1, 1'b0);
    step(1'b0, 4'b0, '0, 1'b1, 1'b0);
    // saturation, then clear coincident with an erroneous accept
    for (int i = 0; i < 5; i++) step(1'b1, 4'b1011, rnd_data(), 1'b1, 1'b0);
    step(1'b1, 4'b0000, rnd_data(), 1'b1, 1'b1);
    step(1'b0, 4'b0, '0, 1'b1, 1'b0);
    step(1'b0, 4'b0110, rnd_data(), 1'b1, 1'b0);
    // reset while FULL
    step(1'b1, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(1'b1, 4'b0100, rnd_data(), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rnd_sel(), rnd_data(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);
    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
